// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit 7-segment display and a 5-column LED matrix.
// Frames are double-buffered and swapped only at scan wraps, so a displayed frame never tears.
module display_scan_driver #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seg_in,
  input  logic [34:0] mat_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  digit_en,
  output logic [6:0]  row_out,
  output logic [4:0]  col_en,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    dig_idx_reg, dig_idx_next;
  logic [2:0]    col_idx_reg, col_idx_next;
  logic [31:0]   active_seg_reg, active_seg_next;
  logic [31:0]   pend_seg_reg, pend_seg_next;
  logic          seg_pend_reg, seg_pend_next;
  logic [34:0]   active_mat_reg, active_mat_next;
  logic [34:0]   pend_mat_reg, pend_mat_next;
  logic          mat_pend_reg, mat_pend_next;
  logic          frame_done_reg, frame_done_next;

  logic slot_end;
  logic dig_wrap;
  logic col_wrap;

  assign slot_end = (cnt_reg == CNT_LAST);
  assign dig_wrap = slot_end && (dig_idx_reg == 2'd3);
  assign col_wrap = slot_end && (col_idx_reg == 3'd4);

  // Scan position: counter within a slot plus the digit and column indices.
  always_comb begin
    cnt_next     = cnt_reg + CW'(1);
    dig_idx_next = dig_idx_reg;
    col_idx_next = col_idx_reg;
    if (slot_end) begin
      cnt_next     = '0;
      dig_idx_next = dig_idx_reg + 2'd1;
      col_idx_next = (col_idx_reg == 3'd4) ? 3'd0 : col_idx_reg + 3'd1;
    end
  end

  // A load on a wrap edge bypasses the pending buffer and goes live immediately.
  always_comb begin
    pend_seg_next   = pend_seg_reg;
    seg_pend_next   = seg_pend_reg;
    active_seg_next = active_seg_reg;
    if (load) begin
      pend_seg_next = seg_in;
      seg_pend_next = 1'b1;
    end
    if (dig_wrap) begin
      if (load) begin
        active_seg_next = seg_in;
        seg_pend_next   = 1'b0;
      end else if (seg_pend_reg) begin
        active_seg_next = pend_seg_reg;
        seg_pend_next   = 1'b0;
      end
    end
  end

  always_comb begin
    pend_mat_next   = pend_mat_reg;
    mat_pend_next   = mat_pend_reg;
    active_mat_next = active_mat_reg;
    if (load) begin
      pend_mat_next = mat_in;
      mat_pend_next = 1'b1;
    end
    if (col_wrap) begin
      if (load) begin
        active_mat_next = mat_in;
        mat_pend_next   = 1'b0;
      end else if (mat_pend_reg) begin
        active_mat_next = pend_mat_reg;
        mat_pend_next   = 1'b0;
      end
    end
  end

  assign frame_done_next = col_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      dig_idx_reg    <= '0;
      col_idx_reg    <= '0;
      active_seg_reg <= '0;
      pend_seg_reg   <= '0;
      seg_pend_reg   <= 1'b0;
      active_mat_reg <= '0;
      pend_mat_reg   <= '0;
      mat_pend_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      dig_idx_reg    <= dig_idx_next;
      col_idx_reg    <= col_idx_next;
      active_seg_reg <= active_seg_next;
      pend_seg_reg   <= pend_seg_next;
      seg_pend_reg   <= seg_pend_next;
      active_mat_reg <= active_mat_next;
      pend_mat_reg   <= pend_mat_next;
      mat_pend_reg   <= mat_pend_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Split the active frames into per-digit and per-column patterns.
  logic [7:0] seg_slice [4];
  logic [6:0] mat_slice [5];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_seg_slice
      assign seg_slice[gi] = active_seg_reg[8*gi +: 8];
    end
    for (gi = 0; gi < 5; gi++) begin : g_mat_slice
      assign mat_slice[gi] = active_mat_reg[7*gi +: 7];
    end
  endgenerate

  logic blank;
  assign blank = (cnt_reg < BLANK_CNT);

  always_comb begin
    seg_out  = '0;
    digit_en = '0;
    row_out  = '0;
    col_en   = '0;
    if (!blank) begin
      seg_out  = seg_slice[dig_idx_reg];
      digit_en = 4'(1) << dig_idx_reg;
      row_out  = mat_slice[col_idx_reg];
      col_en   = 5'(1) << col_idx_reg;
    end
  end

  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: the driver pushes per-cycle expectations from an
// arithmetic model of slots and wrap boundaries; a negedge monitor pops and compares.
module tb_display_scan_driver;

  localparam int P = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] seg_in;
  logic [34:0] mat_in;
  logic [7:0]  seg_out;
  logic [3:0]  digit_en;
  logic [6:0]  row_out;
  logic [4:0]  col_en;
  logic        frame_done;

  display_scan_driver #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .load(load), .seg_in(seg_in), .mat_in(mat_in),
    .seg_out(seg_out), .digit_en(digit_en), .row_out(row_out), .col_en(col_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected output word: {seg_out, digit_en, row_out, col_en, frame_done}
  logic [24:0] exp_q[$];
  int          cyc_q[$];
  int          ld_t[$];
  logic [31:0] ld_seg[$];
  logic [34:0] ld_mat[$];

  int  t;
  bit  model_valid;
  int  pass_cnt;
  int  fail_cnt;
  bit  driving_done;

  // A load captured at the end of cycle L is shown once a wrap edge at or after L has passed.
  // Digit wraps end cycles 4P*m-1; column wraps end cycles 5P*m-1.
  function automatic logic [24:0] model(input int tc);
    logic [31:0] sf;
    logic [34:0] mf;
    logic [7:0]  s;
    logic [3:0]  d;
    logic [6:0]  r;
    logic [4:0]  c;
    logic        fd;
    int sb, mb, slot, dg, cl;
    sf = '0;
    mf = '0;
    sb = 4 * P * (tc / (4 * P)) - 1;
    mb = 5 * P * (tc / (5 * P)) - 1;
    for (int i = 0; i < ld_t.size(); i++) begin
      if (ld_t[i] <= sb) sf = ld_seg[i];
      if (ld_t[i] <= mb) mf = ld_mat[i];
    end
    slot = tc / P;
    dg = slot % 4;
    cl = slot % 5;
    s = '0; d = '0; r = '0; c = '0;
    if ((tc % P) >= B) begin
      s = sf[8*dg +: 8];
      d = 4'(1) << dg;
      r = mf[7*cl +: 7];
      c = 5'(1) << cl;
    end
    fd = (tc > 0) && (tc % (5 * P) == 0);
    return {s, d, r, c, fd};
  endfunction

  // One clock cycle of stimulus; inputs are applied just after the rising edge.
  task automatic do_cycle(input bit r_v, input bit l_v, input logic [31:0] s_v,
                          input logic [34:0] m_v);
    rst    = r_v;
    load   = l_v;
    seg_in = s_v;
    mat_in = m_v;
    if (model_valid) begin
      exp_q.push_back(model(t));
      cyc_q.push_back(t);
    end
    if (l_v && !r_v) begin
      ld_t.push_back(t);
      ld_seg.push_back(s_v);
      ld_mat.push_back(m_v);
      $display("load  t=%0d seg=%08h mat=%09h", t, s_v, m_v);
    end
    @(posedge clk);
    #1;
    if (r_v) begin
      t = 0;
      ld_t.delete();
      ld_seg.delete();
      ld_mat.delete();
      model_valid = 1'b1;
    end else begin
      t++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, $urandom, {$urandom, $urandom});
  endtask

  task automatic reset_n(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, '0, '0);
  endtask

  // Monitor: every cycle is an output presentation; compare against the oldest expectation.
  initial begin
    logic [24:0] got, expv;
    int tc;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        tc = cyc_q.pop_front();
        got = {seg_out, digit_en, row_out, col_en, frame_done};
        if (got !== expv) begin
          fail_cnt++;
          $display("FAIL cycle t=%0d outputs {seg,dig,row,col,fd} got=%07h required=%07h",
                   tc, got, expv);
        end else begin
          pass_cnt++;
        end
      end else if (driving_done) begin
        break;
      end
    end
  end

  initial begin
    int budget;
    t = 0;
    model_valid = 1'b0;
    pass_cnt = 0;
    fail_cnt = 0;
    driving_done = 1'b0;
    rst = 1'b1;
    load = 1'b0;
    seg_in = '0;
    mat_in = '0;

    // Reset, then segment and matrix load at cycle 2 (column 2 lit).
    reset_n(3);
    idle(2);
    do_cycle(1'b0, 1'b1, 32'h664F5B06, 35'h7F << 14);
    idle(47);

    // Last-wins overwrite: loads at cycles 3 and 9.
    reset_n(1);
    idle(3);
    do_cycle(1'b0, 1'b1, 32'h00000006, 35'h1);
    idle(5);
    do_cycle(1'b0, 1'b1, 32'h0000003F, 35'h2);
    idle(30);

    // Load exactly on the first digit wrap edge (cycle 15).
    reset_n(1);
    idle(15);
    do_cycle(1'b0, 1'b1, 32'h0000007F, 35'h3);
    idle(30);

    // Mid-scan reset at cycle 50 discards a pending frame.
    reset_n(1);
    idle(40);
    do_cycle(1'b0, 1'b1, $urandom, {$urandom, $urandom});
    idle(9);
    reset_n(1);
    idle(45);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bit r_v, l_v;
      r_v = ($urandom_range(0, 299) == 0);
      l_v = ($urandom_range(0, 11) == 0);
      do_cycle(r_v, l_v, $urandom, {$urandom, $urandom});
    end

    driving_done = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
